lnrv_csr_debug: RTL and testbench
=================================

LNRV_CSR_DEBUG -- requirements
Module: lnrv_csr_debug

Interface
REQ-001 SHALL have parameter DBG_XDEBUGVER, default 4'd4, the read-only dcsr.xdebugver value.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmt_dcsr  input  1  debug-entry commit pulse from the EXU debug stage.
REQ-005 SHALL have port cmt_dpc  input  32  PC to save into dpc on entry.
REQ-006 SHALL have port cmt_dcause  input  3  entry cause to save into dcsr.cause.
REQ-007 SHALL have port dret_req  input  1  dret instruction dispatched.
REQ-008 SHALL have port csr_rd_en / csr_wr_en  input  1 each  CSR access strobes.
REQ-009 SHALL have port csr_addr  input  12  CSR address.
REQ-010 SHALL have port csr_wdata  input  32  CSR write data.
REQ-011 SHALL have port csr_rdata  output  32  read data, combinational from csr_addr.
REQ-012 SHALL have port csr_ill  output  1  illegal access or illegal dret.
REQ-013 SHALL have port d_mode  output  1  hart in debug mode.
REQ-014 SHALL have port dbg_step  output  1  dcsr.step & ~d_mode.
REQ-015 SHALL have ports dcsr_ebreakm, dcsr_stepie  output  1 each  dcsr fields.
REQ-016 SHALL have ports dret_flush_req  output  1, dret_flush_ack  input  1, dret_flush_pc  output  32.

Function
REQ-017 SHALL decode dcsr 0x7B0, dpc 0x7B1, dscratch0 0x7B2, dscratch1 0x7B3; other addresses give csr_rdata=0 and no hit.
REQ-018 SHALL make dcsr read as {xdebugver[31:28], 0[27:16], ebreakm[15], 0[14:12], stepie[11], 0[10:9], cause[8:6], 0[5:3], step[2], prv[1:0]=2'b11}.
REQ-019 SHALL allow writes only to ebreakm, stepie, step in dcsr; xdebugver, cause and prv ignore writes.
REQ-020 SHALL store dpc bit 0 as 0 (write data [0] dropped); dscratch0/1 fully writable.
REQ-021 SHALL assert csr_ill when csr_rd_en|csr_wr_en hits a debug CSR while d_mode=0; the write is then discarded and csr_rdata=0.
REQ-022 SHALL implement FSM RUN -> DBG -> EXIT; RUN: d_mode=0; DBG: d_mode=1; EXIT: d_mode=1, dret_flush_req=1.
REQ-023 SHALL, in RUN on cmt_dcsr=1, load dpc<=cmt_dpc&~1, cause<=cmt_dcause and go to DBG on the next edge.
REQ-024 SHALL ignore cmt_dcsr in DBG and EXIT.
REQ-025 SHALL, in DBG on dret_req=1, go to EXIT; dret_req in RUN asserts csr_ill for that cycle and is otherwise ignored.
REQ-026 SHALL drive dret_flush_pc=dpc, held stable while dret_flush_req=1.
REQ-027 SHALL, in EXIT, go to RUN on the edge where dret_flush_req&dret_flush_ack; d_mode falls that edge.
REQ-028 SHALL, with a CSR write to dpc and dret_req in the same DBG cycle, apply the write first, so dret_flush_pc shows the new value.
REQ-029 SHALL block CSR writes during EXIT, with csr_ill=0.
REQ-030 SHALL make d_mode and dbg_step register-sourced or single-gate, with no combinational path from cmt_dcsr.

Reset
REQ-031 SHALL reset to RUN, d_mode=0, dpc=0, dscratch0/1=0, cause=0, ebreakm=0, stepie=0, step=0.
REQ-032 SHALL, when reset asserts in EXIT, drop dret_flush_req immediately and return to RUN.

Structure
REQ-033 SHALL place the CSR address constants, dcsr bit positions and FSM state encodings in the shared lnrv package (lnrv_defines).
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 SHALL cover this scenario: reset, then cmt_dcsr=1, cmt_dpc=0x8000_0103, cmt_dcause=3 -> next cycle d_mode=1, dpc reads 0x8000_0102, dcsr reads 0x4000_00C3.
REQ-036 SHALL cover this scenario: in RUN, write 0x7B2 with 0xDEAD_BEEF -> csr_ill=1, and a read after entering debug mode returns 0.
REQ-037 SHALL cover this scenario: in DBG, write dcsr 0xFFFF_FFFF -> read 0x4000_88C7 (cause=3 kept), dbg_step=0 until exit, then dbg_step=1.
REQ-038 SHALL cover this scenario: in DBG, dret_req, ack held low 3 cycles -> dret_flush_req high 4 cycles with pc=dpc, d_mode=1 throughout, RUN after ack.
REQ-039 SHALL cover this scenario: in DBG, same-cycle write dpc=0x100 and dret_req -> dret_flush_pc=0x100.
REQ-040 SHALL cover this scenario: reset_n low mid-EXIT -> dret_flush_req=0 and d_mode=0 asynchronously; cmt_dcsr in EXIT has no effect on dpc.

Source files
------------

// File: rtl/lnrv_defines.sv
// Shared lnrv definitions: debug CSR addresses, dcsr field positions, debug FSM states.
package lnrv_defines;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_DCSR      = 12'h7B0;
  localparam logic [CSR_AW-1:0] CSR_DPC       = 12'h7B1;
  localparam logic [CSR_AW-1:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [CSR_AW-1:0] CSR_DSCRATCH1 = 12'h7B3;

  localparam int unsigned DCSR_XDEBUGVER_LSB = 28;
  localparam int unsigned DCSR_EBREAKM       = 15;
  localparam int unsigned DCSR_STEPIE        = 11;
  localparam int unsigned DCSR_CAUSE_LSB     = 6;
  localparam int unsigned DCSR_STEP          = 2;
  localparam int unsigned DCSR_PRV_LSB       = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DBG  = 2'd1,
    ST_EXIT = 2'd2
  } dbg_state_e;

  // Assemble the architectural dcsr view; prv is hard-wired to machine mode.
  function automatic logic [XLEN-1:0] dcsr_pack(input logic [3:0] xdebugver,
                                                input logic       ebreakm,
                                                input logic       stepie,
                                                input logic [2:0] cause,
                                                input logic       step);
    logic [XLEN-1:0] v;
    v = '0;
    v[DCSR_XDEBUGVER_LSB +: 4] = xdebugver;
    v[DCSR_EBREAKM]            = ebreakm;
    v[DCSR_STEPIE]             = stepie;
    v[DCSR_CAUSE_LSB +: 3]     = cause;
    v[DCSR_STEP]               = step;
    v[DCSR_PRV_LSB +: 2]       = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/lnrv_csr_debug.sv
// Debug-mode CSRs (dcsr/dpc/dscratch0/1) and the RUN/DBG/EXIT debug-mode sequencer.
module lnrv_csr_debug
  import lnrv_defines::*;
#(
  parameter logic [3:0] DBG_XDEBUGVER = 4'd4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmt_dcsr,
  input  logic [XLEN-1:0]     cmt_dpc,
  input  logic [2:0]          cmt_dcause,
  input  logic                dret_req,
  input  logic                csr_rd_en,
  input  logic                csr_wr_en,
  input  logic [CSR_AW-1:0]   csr_addr,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                csr_ill,
  output logic                d_mode,
  output logic                dbg_step,
  output logic                dcsr_ebreakm,
  output logic                dcsr_stepie,
  output logic                dret_flush_req,
  input  logic                dret_flush_ack,
  output logic [XLEN-1:0]     dret_flush_pc
);

  dbg_state_e      state_q;
  dbg_state_e      state_nxt;

  logic [XLEN-1:0] dpc_q;
  logic [XLEN-1:0] dscratch0_q;
  logic [XLEN-1:0] dscratch1_q;
  logic [2:0]      cause_q;
  logic            step_q;

  logic            sel_dcsr;
  logic            sel_dpc;
  logic            sel_ds0;
  logic            sel_ds1;
  logic            csr_hit;
  logic            csr_wr_ok;
  logic            entry;

  assign sel_dcsr = (csr_addr == CSR_DCSR);
  assign sel_dpc  = (csr_addr == CSR_DPC);
  assign sel_ds0  = (csr_addr == CSR_DSCRATCH0);
  assign sel_ds1  = (csr_addr == CSR_DSCRATCH1);
  assign csr_hit  = sel_dcsr | sel_dpc | sel_ds0 | sel_ds1;

  // Writes land only in DBG; EXIT silently blocks them, RUN flags them illegal.
  assign csr_wr_ok = csr_wr_en & csr_hit & (state_q == ST_DBG);
  assign entry     = cmt_dcsr & (state_q == ST_RUN);

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_RUN:  if (cmt_dcsr) state_nxt = ST_DBG;
      ST_DBG:  if (dret_req) state_nxt = ST_EXIT;
      ST_EXIT: if (dret_flush_req & dret_flush_ack) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // State register plus registered mode outputs derived from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      d_mode         <= 1'b0;
      dret_flush_req <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      d_mode         <= (state_nxt != ST_RUN);
      dret_flush_req <= (state_nxt == ST_EXIT);
    end
  end

  // CSR storage; entry capture and software writes are mutually exclusive by state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dpc_q        <= '0;
      dscratch0_q  <= '0;
      dscratch1_q  <= '0;
      cause_q      <= '0;
      step_q       <= 1'b0;
      dcsr_ebreakm <= 1'b0;
      dcsr_stepie  <= 1'b0;
    end else if (entry) begin
      dpc_q   <= cmt_dpc & ~XLEN'(1);
      cause_q <= cmt_dcause;
    end else if (csr_wr_ok) begin
      if (sel_dcsr) begin
        dcsr_ebreakm <= csr_wdata[DCSR_EBREAKM];
        dcsr_stepie  <= csr_wdata[DCSR_STEPIE];
        step_q       <= csr_wdata[DCSR_STEP];
      end
      if (sel_dpc) dpc_q       <= csr_wdata & ~XLEN'(1);
      if (sel_ds0) dscratch0_q <= csr_wdata;
      if (sel_ds1) dscratch1_q <= csr_wdata;
    end
  end

  // Read mux; debug CSRs read as zero outside debug mode
  always_comb begin
    csr_rdata = '0;
    if (d_mode) begin
      if (sel_dcsr) csr_rdata = dcsr_pack(DBG_XDEBUGVER, dcsr_ebreakm, dcsr_stepie,
                                          cause_q, step_q);
      if (sel_dpc)  csr_rdata = dpc_q;
      if (sel_ds0)  csr_rdata = dscratch0_q;
      if (sel_ds1)  csr_rdata = dscratch1_q;
    end
  end

  assign csr_ill = ((csr_rd_en | csr_wr_en) & csr_hit & ~d_mode)
                 | (dret_req & (state_q == ST_RUN));

  assign dbg_step      = step_q & ~d_mode;
  assign dret_flush_pc = dpc_q;

endmodule

// File: tb/tb_lnrv_csr_debug.sv
// Directed self-checking bench for lnrv_csr_debug.
module tb_lnrv_csr_debug;

  logic        clk;
  logic        reset_n;
  logic        cmt_dcsr;
  logic [31:0] cmt_dpc;
  logic [2:0]  cmt_dcause;
  logic        dret_req;
  logic        csr_rd_en;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ill;
  logic        d_mode;
  logic        dbg_step;
  logic        dcsr_ebreakm;
  logic        dcsr_stepie;
  logic        dret_flush_req;
  logic        dret_flush_ack;
  logic [31:0] dret_flush_pc;

  int tests;
  int fails;

  lnrv_csr_debug #(.DBG_XDEBUGVER(4'd4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmt_dcsr      (cmt_dcsr),
    .cmt_dpc       (cmt_dpc),
    .cmt_dcause    (cmt_dcause),
    .dret_req      (dret_req),
    .csr_rd_en     (csr_rd_en),
    .csr_wr_en     (csr_wr_en),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .csr_ill       (csr_ill),
    .d_mode        (d_mode),
    .dbg_step      (dbg_step),
    .dcsr_ebreakm  (dcsr_ebreakm),
    .dcsr_stepie   (dcsr_stepie),
    .dret_flush_req(dret_flush_req),
    .dret_flush_ack(dret_flush_ack),
    .dret_flush_pc (dret_flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmt_dcsr  = 1'b0;
    dret_req  = 1'b0;
    csr_rd_en = 1'b0;
    csr_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle(); cmt_dpc = '0; cmt_dcause = '0;
    csr_addr = 12'h7B0; csr_wdata = '0; dret_flush_ack = 1'b0;
    #3;
    tests++;
    if ({d_mode, dret_flush_req, dbg_step, dcsr_ebreakm, dcsr_stepie, csr_ill} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000000",
               {d_mode, dret_flush_req, dbg_step, dcsr_ebreakm, dcsr_stepie, csr_ill});
    end
    tests++;
    if (dret_flush_pc !== 32'h0) begin
      fails++; $display("FAIL reset_dpc: got %h expected 00000000", dret_flush_pc);
    end
    tick(); reset_n = 1'b1; tick();
  endtask

  task automatic test_run_access();
    csr_wr_en = 1'b1; csr_addr = 12'h7B2; csr_wdata = 32'hDEAD_BEEF; #1;
    tests++;
    if (csr_ill !== 1'b1) begin fails++; $display("FAIL run_write_ill: got %b expected 1", csr_ill); end
    tests++;
    if (csr_rdata !== 32'h0) begin fails++; $display("FAIL run_rdata: got %h expected 0", csr_rdata); end
    tick(); idle();
    csr_addr = 12'h300; csr_rd_en = 1'b1; #1;
    tests++;
    if (csr_ill !== 1'b0) begin fails++; $display("FAIL run_nohit_ill: got %b expected 0", csr_ill); end
    idle(); dret_req = 1'b1; #1;
    tests++;
    if (csr_ill !== 1'b1) begin fails++; $display("FAIL run_dret_ill: got %b expected 1", csr_ill); end
    tick(); idle(); #1;
    tests++;
    if ({d_mode, dret_flush_req} !== 2'b00) begin
      fails++; $display("FAIL run_dret_ignored: got %b expected 00", {d_mode, dret_flush_req});
    end
  endtask

  task automatic test_entry();
    cmt_dcsr = 1'b1; cmt_dpc = 32'h8000_0103; cmt_dcause = 3'd3; #1;
    tests++;
    if (d_mode !== 1'b0) begin fails++; $display("FAIL entry_comb: got %b expected 0", d_mode); end
    tick(); idle();
    csr_rd_en = 1'b1; csr_addr = 12'h7B1; #1;
    tests++;
    if (d_mode !== 1'b1) begin fails++; $display("FAIL entry_dmode: got %b expected 1", d_mode); end
    tests++;
    if (csr_rdata !== 32'h8000_0102) begin
      fails++; $display("FAIL entry_dpc: got %h expected 80000102", csr_rdata);
    end
    csr_addr = 12'h7B0; #1;
    tests++;
    if (csr_rdata !== 32'h4000_00C3) begin
      fails++; $display("FAIL entry_dcsr: got %h expected 400000c3", csr_rdata);
    end
    csr_addr = 12'h7B2; #1;
    tests++;
    if (csr_rdata !== 32'h0 || csr_ill !== 1'b0) begin
      fails++; $display("FAIL ds0_discarded: got %h ill %b expected 0 ill 0", csr_rdata, csr_ill);
    end
    csr_addr = 12'h7B4; #1;
    tests++;
    if (csr_rdata !== 32'h0) begin fails++; $display("FAIL unmapped_rd: got %h expected 0", csr_rdata); end
    // Second commit while already in debug mode must not disturb dpc/cause
    idle(); cmt_dcsr = 1'b1; cmt_dpc = 32'h1111_2222; cmt_dcause = 3'd5;
    tick(); idle(); csr_addr = 12'h7B1; #1;
    tests++;
    if (csr_rdata !== 32'h8000_0102) begin
      fails++; $display("FAIL dbg_cmt_ignored: got %h expected 80000102", csr_rdata);
    end
  endtask

  task automatic test_csr_write();
    csr_wr_en = 1'b1; csr_addr = 12'h7B0; csr_wdata = 32'hFFFF_FFFF;
    tick(); idle(); #1;
    tests++;
    if (csr_rdata !== 32'h4000_88C7) begin
      fails++; $display("FAIL dcsr_write: got %h expected 400088c7", csr_rdata);
    end
    tests++;
    if ({dbg_step, dcsr_ebreakm, dcsr_stepie} !== 3'b011) begin
      fails++; $display("FAIL dcsr_fields: got %b expected 011", {dbg_step, dcsr_ebreakm, dcsr_stepie});
    end
    csr_wr_en = 1'b1; csr_addr = 12'h7B1; csr_wdata = 32'h1234_5677;
    tick(); idle(); #1;
    tests++;
    if (csr_rdata !== 32'h1234_5676) begin
      fails++; $display("FAIL dpc_bit0: got %h expected 12345676", csr_rdata);
    end
    csr_wr_en = 1'b1; csr_addr = 12'h7B3; csr_wdata = 32'hA5A5_5A5A;
    tick(); idle(); #1;
    tests++;
    if (csr_rdata !== 32'hA5A5_5A5A) begin
      fails++; $display("FAIL ds1_write: got %h expected a5a55a5a", csr_rdata);
    end
  endtask

  task automatic test_dret();
    dret_req = 1'b1; dret_flush_ack = 1'b0;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dret_flush_ack = 1'b1;
      // Write attempt during EXIT: blocked, not illegal
      if (i == 1) begin csr_wr_en = 1'b1; csr_addr = 12'h7B2; csr_wdata = 32'h0BAD_F00D; end
      #1;
      tests++;
      if ({dret_flush_req, d_mode, dbg_step} !== 3'b110 || dret_flush_pc !== 32'h1234_5676
          || csr_ill !== 1'b0) begin
        fails++;
        $display("FAIL exit_hold%0d: req/dm/step %b pc %h ill %b expected 110 pc 12345676 ill 0",
                 i, {dret_flush_req, d_mode, dbg_step}, dret_flush_pc, csr_ill);
      end
      tick(); idle();
    end
    dret_flush_ack = 1'b0; #1;
    tests++;
    if ({dret_flush_req, d_mode, dbg_step} !== 3'b001) begin
      fails++; $display("FAIL exit_done: got %b expected 001", {dret_flush_req, d_mode, dbg_step});
    end
  endtask

  task automatic test_back_to_back();
    cmt_dcsr = 1'b1; cmt_dpc = 32'h0000_2000; cmt_dcause = 3'd4;
    tick(); idle(); csr_addr = 12'h7B0; #1;
    tests++;
    if (csr_rdata !== 32'h4000_8907 || dbg_step !== 1'b0) begin
      fails++; $display("FAIL reentry_dcsr: got %h step %b expected 40008907 step 0", csr_rdata, dbg_step);
    end
    csr_addr = 12'h7B2; #1;
    tests++;
    if (csr_rdata !== 32'h0) begin fails++; $display("FAIL exit_wr_blocked: got %h expected 0", csr_rdata); end
    csr_wr_en = 1'b1; csr_addr = 12'h7B1; csr_wdata = 32'h0000_0100; dret_req = 1'b1;
    tick(); idle(); #1;
    tests++;
    if (dret_flush_req !== 1'b1 || dret_flush_pc !== 32'h0000_0100) begin
      fails++; $display("FAIL wr_dret_same: req %b pc %h expected 1 pc 00000100", dret_flush_req, dret_flush_pc);
    end
  endtask

  task automatic test_reset_exit();
    cmt_dcsr = 1'b1; cmt_dpc = 32'h0000_5555; cmt_dcause = 3'd1;
    tick(); idle(); #1;
    tests++;
    if (dret_flush_pc !== 32'h0000_0100 || dret_flush_req !== 1'b1) begin
      fails++; $display("FAIL exit_cmt_ignored: pc %h req %b expected 00000100 1", dret_flush_pc, dret_flush_req);
    end
    #1 reset_n = 1'b0; #1;
    tests++;
    if ({dret_flush_req, d_mode} !== 2'b00) begin
      fails++; $display("FAIL async_reset_exit: got %b expected 00", {dret_flush_req, d_mode});
    end
    tick(); reset_n = 1'b1; tick(); #1;
    tests++;
    if ({dret_flush_req, d_mode, dbg_step} !== 3'b000 || dret_flush_pc !== 32'h0) begin
      fails++; $display("FAIL post_reset: got %b pc %h expected 000 pc 0",
                        {dret_flush_req, d_mode, dbg_step}, dret_flush_pc);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_run_access();
    test_entry();
    test_csr_write();
    test_dret();
    test_back_to_back();
    test_reset_exit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
